// File: rtl/spi_i2s_bridge.sv
// SPI-to-I2S audio bridge: SPI words are tagged left/right, buffered in a FIFO and
// replayed as one-bit-delayed I2S. Define SPI_I2S_BRIDGE_MONO_DUP_EN for mono duplication.
module spi_i2s_bridge #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                              serial_clk,
  input  logic                              reset,
  input  logic                              spi_chip_select,
  input  logic                              spi_mosi,
  output logic                              i2s_ws,
  output logic                              i2s_sound_bit_out,
  output logic [$clog2(2*SLOT_WIDTH)-1:0]   i2s_bit_number,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int BNW = $clog2(2*SLOT_WIDTH);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(SAMPLE_WIDTH + 1);
  localparam int EW  = SAMPLE_WIDTH + 1;

  logic [CW-1:0]           bit_cnt;
  logic                    spi_tag;
  logic [SAMPLE_WIDTH-2:0] shift;
  logic [SAMPLE_WIDTH-1:0] shift_next;
  logic                    word_done;
  logic                    done_valid;
  logic [EW-1:0]           done_entry;

  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [EW-1:0]           head;
  logic                    fifo_empty;
  logic                    fifo_full;

  logic [SAMPLE_WIDTH-1:0] slot_reg;
  logic [BNW-1:0]          offset;
  logic                    slot_start;
  logic                    pop_attempt;
  logic                    pop_ok;
  logic                    push_ok;

  assign shift_next = {shift, spi_mosi};
  assign word_done  = !spi_chip_select && (bit_cnt == CW'(SAMPLE_WIDTH - 1));

  assign i2s_ws     = (i2s_bit_number >= BNW'(SLOT_WIDTH));
  assign offset     = i2s_ws ? (i2s_bit_number - BNW'(SLOT_WIDTH)) : i2s_bit_number;
  assign slot_start = (offset == '0);

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign head       = mem[rd_ptr];

`ifdef SPI_I2S_BRIDGE_MONO_DUP_EN
  // Right slot replays the word loaded at the left slot, so it never pops.
  assign pop_attempt = slot_start && !i2s_ws;
  assign pop_ok      = pop_attempt && !fifo_empty;
`else
  assign pop_attempt = slot_start;
  assign pop_ok      = pop_attempt && !fifo_empty && (head[EW-1] == i2s_ws);
`endif

  // A full FIFO still accepts a word when a pop frees an entry on the same edge.
  assign push_ok = done_valid && (!fifo_full || pop_ok);

  always_comb begin
    i2s_sound_bit_out = 1'b0;
    for (int k = 1; k <= SAMPLE_WIDTH; k++) begin
      if (offset == BNW'(k)) i2s_sound_bit_out = slot_reg[SAMPLE_WIDTH-k];
    end
  end

  always_ff @(posedge serial_clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= done_entry;
  end

  always_ff @(posedge serial_clk) begin
    if (reset) begin
      i2s_bit_number <= '0;
      bit_cnt        <= '0;
      spi_tag        <= 1'b0;
      shift          <= '0;
      done_valid     <= 1'b0;
      done_entry     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      slot_reg       <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      if (i2s_bit_number == BNW'(2*SLOT_WIDTH - 1)) i2s_bit_number <= '0;
      else                                          i2s_bit_number <= i2s_bit_number + BNW'(1);

      done_valid <= word_done;
      if (spi_chip_select) begin
        bit_cnt <= '0;
        spi_tag <= 1'b0;
      end else begin
        shift <= shift_next[SAMPLE_WIDTH-2:0];
        if (word_done) begin
          bit_cnt    <= '0;
          done_entry <= {spi_tag, shift_next};
          spi_tag    <= ~spi_tag;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end

      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (pop_attempt) slot_reg <= pop_ok ? head[SAMPLE_WIDTH-1:0] : '0;

      case ({push_ok, pop_ok})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase

      if (done_valid && !push_ok)  overflow  <= 1'b1;
      if (pop_attempt && !pop_ok)  underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_i2s_bridge.sv
// Self-checking bench for spi_i2s_bridge: directed scenarios plus random SPI traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_spi_i2s_bridge;

  logic       serial_clk = 1'b0;
  logic       reset;
  logic       spi_chip_select;
  logic       spi_mosi;
  logic       i2s_ws;
  logic       i2s_sound_bit_out;
  logic [5:0] i2s_bit_number;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  always #5 serial_clk = ~serial_clk;

  spi_i2s_bridge #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .serial_clk        (serial_clk),
    .reset             (reset),
    .spi_chip_select   (spi_chip_select),
    .spi_mosi          (spi_mosi),
    .i2s_ws            (i2s_ws),
    .i2s_sound_bit_out (i2s_sound_bit_out),
    .i2s_bit_number    (i2s_bit_number),
    .fifo_level        (fifo_level),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  // Reference model: frame position, SPI assembly and a queue of {tag, word}.
  int          m_pos;
  int          m_bits;
  logic [15:0] m_val;
  bit          m_tag;
  bit          m_pend;
  logic [16:0] m_pend_e;
  logic [16:0] m_q[$];
  logic [15:0] m_slot;
  bit          m_slot_ok;
  bit          m_ovf;
  bit          m_unf;

  logic [15:0] cur;
  logic [15:0] cap_left;
  logic [15:0] cap_right;
  logic [15:0] played[$];
  int          max_lvl;
  bit          sound_seen;

  typedef struct {
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic [15:0] exp_left;
    logic [15:0] exp_right;
    logic [3:0]  exp_level;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic cs, input logic mosi);
    int          off;
    int          ch;
    bit          att;
    bit          popping;
    bit          pushing;
    logic [16:0] hd;
    if (rst) begin
      m_pos = 0; m_bits = 0; m_val = '0; m_tag = 0; m_pend = 0;
      m_q.delete(); m_slot = '0; m_slot_ok = 0; m_ovf = 0; m_unf = 0;
    end else begin
      off = m_pos % 32;
      ch  = m_pos / 32;
`ifdef SPI_I2S_BRIDGE_MONO_DUP_EN
      att = (off == 0) && (ch == 0);
      popping = att && (m_q.size() > 0);
`else
      att = (off == 0);
      popping = att && (m_q.size() > 0);
      if (popping && (m_q[0][16] != (ch == 1))) popping = 0;
`endif
      pushing = m_pend && ((m_q.size() < 8) || popping);
      if (att) begin
        if (popping) begin
          hd = m_q.pop_front();
          m_slot = hd[15:0];
          m_slot_ok = 1;
        end else begin
          m_slot = '0;
          m_slot_ok = 0;
        end
      end
      if (pushing) m_q.push_back(m_pend_e);
      if (att && !popping) m_unf = 1;
      if (m_pend && !pushing) m_ovf = 1;
      m_pend = 0;
      if (cs) begin
        m_bits = 0;
        m_tag  = 0;
      end else begin
        m_val = {m_val[14:0], mosi};
        m_bits++;
        if (m_bits == 16) begin
          m_pend   = 1;
          m_pend_e = {m_tag, m_val};
          m_tag    = !m_tag;
          m_bits   = 0;
        end
      end
      m_pos = (m_pos + 1) % 64;
    end
  endtask

  task automatic compare_outputs();
    int   off;
    logic exp_bit;
    off = m_pos % 32;
    exp_bit = 1'b0;
    if (off >= 1 && off <= 16) exp_bit = m_slot[16-off];
    check("bit_number", 32'(i2s_bit_number), 32'(m_pos));
    check("ws", 32'(i2s_ws), 32'(m_pos >= 32));
    check("sound_bit", 32'(i2s_sound_bit_out), 32'(exp_bit));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input logic rst, input logic cs, input logic mosi);
    int b;
    int o;
    reset = rst;
    spi_chip_select = cs;
    spi_mosi = mosi;
    @(posedge serial_clk);
    model_edge(rst, cs, mosi);
    #1;
    compare_outputs();
    b = int'(i2s_bit_number);
    o = b % 32;
    if (o >= 1 && o <= 16) cur[16-o] = i2s_sound_bit_out;
    if (o == 16) begin
      if (b >= 32) cap_right = cur;
      else         cap_left  = cur;
      if (m_slot_ok) played.push_back(cur);
    end
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    if (i2s_sound_bit_out) sound_seen = 1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) step(1'b0, 1'b0, w[i]);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 200 && m_pos != p; i++) idle(1);
  endtask

  initial begin
    vec_t        vecs[4];
    logic [15:0] sent[$];
    logic [15:0] w;
    logic        cs_r;

    vecs[0] = '{16'hA5C3, 16'h1234, 16'hA5C3, 16'h1234, 4'd2};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 4'd2};
    vecs[2] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 4'd2};
    vecs[3] = '{16'h0000, 16'hC0DE, 16'h0000, 16'hC0DE, 4'd2};

    // Empty FIFO after reset: first left-slot attempt underflows, frame stays silent.
    do_reset(2);
    check("reset_bit_number", 32'(i2s_bit_number), 32'd0);
    check("reset_flags", {30'd0, overflow, underflow}, 32'd0);
    sound_seen = 0;
    step(1'b0, 1'b1, 1'b0);
    check("empty_underflow", 32'(underflow), 32'd1);
    idle(63);
    check("empty_frame_silent", 32'(sound_seen), 32'd0);

    // Reset held 3 cycles mid-word; the next full word must land in the left slot.
    do_reset(2);
    w = 16'h5A3C;
    for (int i = 15; i >= 9; i--) step(1'b0, 1'b0, w[i]);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      check("midword_reset_level", 32'(fifo_level), 32'd0);
      check("midword_reset_outputs", {28'd0, i2s_ws, i2s_sound_bit_out, overflow, underflow}, 32'd0);
    end
    send_word(16'hBEEF);
    idle(20);
    wait_pos(17);
    check("post_reset_word_left", 32'(cap_left), 32'hBEEF);

    // Aborted partial frame followed by a clean word.
    do_reset(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'(i % 2));
    idle(2);
    send_word(16'h00FF);
    idle(1);
    check("abort_level", 32'(fifo_level), 32'd1);
    wait_pos(17);
    check("abort_word_left", 32'(cap_left), 32'h00FF);

`ifndef SPI_I2S_BRIDGE_MONO_DUP_EN
    foreach (vecs[v]) begin
      do_reset(2);
      wait_pos(30);
      send_word(vecs[v].left_in);
      send_word(vecs[v].right_in);
      idle(1);
      check("pair_level", 32'(fifo_level), 32'(vecs[v].exp_level));
      wait_pos(49);
      check("pair_left", 32'(cap_left), 32'(vecs[v].exp_left));
      check("pair_right", 32'(cap_right), 32'(vecs[v].exp_right));
      check("pair_overflow", 32'(overflow), 32'd0);
      check("pair_drained", 32'(fifo_level), 32'd0);
    end

    // 20 back-to-back words overrun the FIFO; the first 8 must still play intact.
    do_reset(2);
    played.delete();
    sent.delete();
    max_lvl = 0;
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      sent.push_back(w);
      send_word(w);
    end
    idle(600);
    check("burst_overflow", 32'(overflow), 32'd1);
    check("burst_max_level", 32'(max_lvl), 32'd8);
    check("burst_played_count", 32'(played.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < played.size(); i++)
      check("burst_word_order", 32'(played[i]), 32'(sent[i]));
`else
    do_reset(2);
    wait_pos(40);
    send_word(16'h8001);
    wait_pos(63);
    idle(1);
    wait_pos(49);
    check("mono_left", 32'(cap_left), 32'h8001);
    check("mono_right", 32'(cap_right), 32'h8001);
    check("mono_overflow", 32'(overflow), 32'd0);
`endif

    // Random traffic with occasional chip-select gaps and resets.
    do_reset(2);
    cs_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        step(1'b1, 1'b1, 1'b0);
      end else begin
        if ($urandom_range(0, 39) == 0) cs_r = !cs_r;
        step(1'b0, cs_r, 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
